// File: rtl/fault_msg_uart_tx_if.sv
// Req/ack handshake carrying 5-bit fault/column event codes from the
// fault identification block (master) to the message transmitter (slave).
interface fault_msg_uart_tx_if;
   logic       req;
   logic [4:0] fault_code;
   logic       ack;

   modport master (output req, output fault_code, input ack);
   modport slave  (input req, input fault_code, output ack);
endinterface

// File: rtl/fault_msg_uart_tx.sv
// Handshake responder + duplicate filter + 8N1 UART that reports each new event code
// as ASCII. Define FAULT_MSG_NEWLINE_EN to terminate every message with 0x0A.
module fault_msg_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic                 clock,
   input  logic                 reset,
   fault_msg_uart_tx_if.slave   hs,
   output logic                 tx,
   output logic                 busy
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_NEXT} state_e;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [4:0]  CODE_NONE = 5'd0;
   localparam logic [4:0]  CODE_BDM  = 5'd15;
   localparam logic [4:0]  CODE_STOP = 5'd31;
`ifdef FAULT_MSG_NEWLINE_EN
   localparam logic [2:0]  LAST_BYTE = 3'd5;
`else
   localparam logic [2:0]  LAST_BYTE = 3'd4;
`endif

   // One character of the message for a code; index 5 is only reached with the terminator.
   function automatic logic [7:0] msg_byte(input logic [4:0] code, input logic [2:0] idx);
      logic [4:0] ones_val;
      logic [7:0] tens_chr;
      logic [7:0] ones_chr;
      ones_val = (code >= 5'd10) ? code - 5'd10 : code;
      tens_chr = (code >= 5'd10) ? "1" : "0";
      ones_chr = 8'h30 + {3'b000, ones_val};
      case (idx)
         3'd0:    msg_byte = (code == CODE_BDM) ? "B" : (code == CODE_STOP) ? "E" : "F";
         3'd1:    msg_byte = (code == CODE_BDM) ? "D" : (code == CODE_STOP) ? "N" : tens_chr;
         3'd2:    msg_byte = (code == CODE_BDM) ? "M" : (code == CODE_STOP) ? "D" : ones_chr;
         3'd3:    msg_byte = "-";
         3'd4:    msg_byte = "#";
         default: msg_byte = 8'h0A;
      endcase
   endfunction

   // Handshake and filter state
   logic       req_meta_q, req_s_q, req_prev_q;
   logic       ack_q, ack_d;
   logic [4:0] code_in_q, code_in_d;
   logic       code_vld_q, code_vld_d;
   logic [4:0] last_code_q, last_code_d;
   logic       pend_full_q, pend_full_d;
   logic [4:0] pend_code_q, pend_code_d;

   // Transmitter state
   state_e     state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0] bit_q, bit_d;
   logic [2:0] byte_idx_q, byte_idx_d;
   logic [4:0] msg_code_q, msg_code_d;
   logic       tx_q, tx_d;

   logic       capture;
   logic       reportable;
   logic       baud_done;
   logic [7:0] cur_byte;

   assign capture    = req_s_q & ~req_prev_q;
   assign reportable = (code_in_q != CODE_NONE) &&
                       ((code_in_q <= CODE_BDM) || (code_in_q == CODE_STOP));
   assign baud_done  = (baud_q == BAUD_LAST);
   assign cur_byte   = msg_byte(msg_code_q, byte_idx_q);

   assign hs.ack = ack_q;
   assign tx     = tx_q;
   assign busy   = pend_full_q | (state_q != S_IDLE);

   // NOTE: every always_comb assigns all its outputs first, so no latches are inferred.
   always_comb begin
      ack_d       = ack_q;
      code_in_d   = code_in_q;
      code_vld_d  = capture;
      last_code_d = last_code_q;
      pend_full_d = pend_full_q;
      pend_code_d = pend_code_q;

      if (capture) begin
         ack_d     = 1'b1;
         code_in_d = hs.fault_code;
      end else if (!req_s_q) begin
         ack_d = 1'b0;
      end

      // LOAD empties the slot first, so a write in the same cycle lands in the freed slot.
      if (state_q == S_LOAD) pend_full_d = 1'b0;

      if (code_vld_q) begin
         if (code_in_q == CODE_NONE) begin
            last_code_d = CODE_NONE;
         end else if (reportable && (code_in_q != last_code_q)) begin
            pend_full_d = 1'b1;
            pend_code_d = code_in_q;
            last_code_d = code_in_q;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      byte_idx_d = byte_idx_q;
      msg_code_d = msg_code_q;

      case (state_q)
         S_IDLE: if (pend_full_q) state_d = S_LOAD;
         S_LOAD: begin
            msg_code_d = pend_code_q;
            byte_idx_d = 3'd0;
            baud_d     = 16'd0;
            state_d    = S_START;
         end
         S_START: begin
            if (baud_done) begin
               baud_d  = 16'd0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_DATA: begin
            if (baud_done) begin
               baud_d = 16'd0;
               bit_d  = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_STOP: begin
            if (baud_done) begin
               baud_d  = 16'd0;
               state_d = S_NEXT;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_NEXT: begin
            if (byte_idx_q == LAST_BYTE) begin
               state_d = S_IDLE;
            end else begin
               byte_idx_d = byte_idx_q + 3'd1;
               state_d    = S_START;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // tx is registered from next-state values so the pin never glitches.
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = cur_byte[bit_d];
         default: tx_d = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         req_meta_q  <= 1'b0;
         req_s_q     <= 1'b0;
         req_prev_q  <= 1'b0;
         ack_q       <= 1'b0;
         code_in_q   <= CODE_NONE;
         code_vld_q  <= 1'b0;
         last_code_q <= CODE_NONE;
         pend_full_q <= 1'b0;
         pend_code_q <= CODE_NONE;
         state_q     <= S_IDLE;
         baud_q      <= 16'd0;
         bit_q       <= 3'd0;
         byte_idx_q  <= 3'd0;
         msg_code_q  <= CODE_NONE;
         tx_q        <= 1'b1;
      end else begin
         req_meta_q  <= hs.req;
         req_s_q     <= req_meta_q;
         req_prev_q  <= req_s_q;
         ack_q       <= ack_d;
         code_in_q   <= code_in_d;
         code_vld_q  <= code_vld_d;
         last_code_q <= last_code_d;
         pend_full_q <= pend_full_d;
         pend_code_q <= pend_code_d;
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         byte_idx_q  <= byte_idx_d;
         msg_code_q  <= msg_code_d;
         tx_q        <= tx_d;
      end
   end

endmodule

// File: doc/fault_msg_uart_tx.md
# fault_msg_uart_tx

Responder end of the fault/column-code req/ack handshake, and the UART transmitter that reports each new detection to the base station. Accepts 5-bit event codes from the fault identification block and drops repeated codes. Formats each accepted code as a short ASCII message and shifts it out as 8N1 serial on `tx`. Sits between fault identification and the board's UART TX pin.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); legal range 4..65535.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  handshake request from the producer. The producer drives it on the falling edge of `clock`, so it is treated as asynchronous.
- `fault_code`  in  5  event code; stable whenever `req` is high.
- `ack`  out  1  handshake acknowledge.
- `tx`  out  1  UART serial output; idles high.
- `busy`  out  1  high while a message is being shifted out or one is pending.

## Operation
- `req` passes through a 2-flop synchronizer to give `req_s`. A rising edge of `req_s` is a capture event.
- On a capture event, `fault_code` is latched into `code_in`.
- Code classes:
  - 1..14 and 15 (BDM) and 31 (STOP) are reportable.
  - 0 (NONE) sets `last_code` to 0 and queues nothing.
  - 16..30 are ignored; `last_code` is unchanged.
- Duplicate filter: a reportable code equal to `last_code` is dropped. Otherwise it is written to the single pending slot and `last_code` takes its value.
- Pending slot holds one entry; latest code wins. If the slot is full, the new code overwrites it and the older pending code is lost.
- Message formats, all ASCII, sent LSB first:
  - codes 1..14: 'F', tens digit, ones digit, '-', '#'. Example: code 7 gives "F07-#".
  - code 15: "BDM-#".
  - code 31: "END-#".
- TX FSM states: IDLE, LOAD, START, DATA, STOP, NEXT.
  - IDLE -> LOAD when the pending slot is full. LOAD moves the slot into `msg_code`, empties the slot and sets byte index = 0.
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, each held for CLKS_PER_BIT cycles.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles.
  - NEXT: increments the byte index; returns to START until the last byte is done, then goes to IDLE.
- Bit counter is 3 bits and wraps at 8. The baud counter is 16 bits and reloads at CLKS_PER_BIT-1.

## Timing
- Reset values: `ack`=0, `tx`=1, `busy`=0. FSM in IDLE, pending slot empty, `last_code`=0, synchronizer flops 0.
- Reset mid-message: `tx` returns to 1 immediately (asynchronous). The rest of the message is discarded.
- Capture happens 2 cycles after `req` rises (synchronizer latency). `ack` rises on the cycle after capture.
- `ack` falls on the cycle after `req_s` is seen low. The next capture requires a fresh rising edge of `req_s`.
- A `req` high pulse of 1 cycle must still be captured.
- Pending write to `tx` start bit: 2 cycles (LOAD, then the first START cycle).
- One byte takes 10*CLKS_PER_BIT cycles. NEXT adds 1 cycle per byte.
- `busy` is high from the cycle after a pending write until the cycle after the final STOP bit ends. It is also high whenever the slot is full.
- Simultaneous pending write and LOAD: LOAD takes the old slot contents. The new code lands in the now-empty slot, so nothing is lost.

## Configuration
- `FAULT_MSG_NEWLINE_EN`:
  - Defined: every message ends with 0x0A after '#', giving 6 bytes per message.
  - Undefined: 5 bytes, no terminator.

## Test plan
- CLKS_PER_BIT=4: reset, then handshake `fault_code`=5 -> `ack` high 3 cycles after `req` rises. `tx` carries "F05-#" (0x46 0x30 0x35 0x2D 0x23), each byte 40 cycles plus 1 NEXT cycle.
- Send 5, then 5 again, then 0, then 5 -> exactly two "F05-#" messages; the second 5 is filtered.
- Send 15 while "F05-#" is mid-transmission, then 31, then 12, all before the first message ends -> "F05-#" followed by "F12-#" only; 15 and 31 are overwritten.
- Send code 20 -> `ack` completes the handshake normally; `tx` stays 1 and `busy` stays 0.
- Assert `reset` low during the DATA bits of the second byte -> `tx`=1 and `ack`=0 immediately. After release, code 5 is sent again because `last_code` is cleared.
- With `FAULT_MSG_NEWLINE_EN` defined, send 31 -> "END-#" then 0x0A; `busy` falls 1 cycle after the sixth stop bit.
